paper_trace_monitor: RTL and testbench
======================================

Name: paper_trace_monitor

Overview:
- Passive observer on the paperProcessor status outputs registerCount, programCount and stateCount.
- Samples them on each enabled clock, checks that stateCount advances legally, and timestamps every change.
- Buffers records in a FIFO that a host or bench drains over a valid/ready read port.
- It is the consumer end of the processor's observability interface, replacing ad-hoc $monitor tracing with a synthesizable trace path.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_W, 8, timestamp width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clk_en  input  1  sample enable, same meaning as the processor's clk_en.
- registerCount  input  3  observed processor register count.
- programCount  input  2  observed processor program count.
- stateCount  input  2  observed processor state count.
- trace_valid  output  1  FIFO head holds a record.
- trace_ready  input  1  consumer accepts the head this cycle.
- trace_data  output  TS_W+7  head record {timestamp, registerCount, programCount, stateCount}.
- trace_count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; at least one record was dropped.
- drop_count  output  8  dropped records, saturating at 255.
- seq_error  output  1  sticky; an illegal stateCount transition was seen.
- err_snapshot  output  14  {prev sample, cur sample} of the first illegal transition.

Behaviour:
- Reset (asynchronous, immediate): all outputs go to 0. This covers trace_valid, trace_data, trace_count, overflow, drop_count, seq_error and err_snapshot. The FIFO empties, the timestamp counter is 0, and the primed flag clears.
- Sample: cur = {registerCount, programCount, stateCount}. Sampling happens only on rising clk edges with clk_en=1.
- clk_en=0: no sampling, timestamp frozen, no checking. The read port still operates.
- Timestamp: TS_W-bit counter that increments once per enabled cycle and wraps to 0 after all-ones. The first enabled cycle after reset records ts=0.
- First enabled cycle after reset (primed=0): always push {ts, cur}, then set primed. No sequence check on this cycle.
- Later enabled cycles: push {ts, cur} iff cur != prev.
- prev updates to cur on every enabled cycle.
- Sequence check: applies when cur.stateCount != prev.stateCount. The transition is legal iff cur.stateCount == (prev.stateCount+1) mod 4, so 3->0 is legal.
  - Holding stateCount is legal.
  - Illegal: seq_error <= 1. err_snapshot <= {prev, cur} only if seq_error was 0 beforehand; later errors do not overwrite it.
  - The offending sample is still recorded.
- FIFO:
  - Show-ahead: trace_data is the oldest entry while trace_valid=1, and 0 when empty.
  - A push is visible on trace_valid/trace_data one cycle after the sampling edge.
  - Pop occurs on a clk edge when trace_valid && trace_ready, independent of clk_en.
  - trace_ready while empty is ignored.
- Full plus push, no pop: the record is dropped. overflow <= 1 and drop_count increments, saturating at 255. The FIFO is unchanged.
- Full plus push plus pop in the same cycle: both happen, no drop, and occupancy stays DEPTH.
- Empty plus push: trace_valid rises next cycle. No same-cycle bypass to a pop.
- Pointers wrap modulo DEPTH. trace_count equals pushes minus pops accepted and always lies in 0..DEPTH.
- Reset asserted mid-stream: the FIFO contents are discarded. After release, the first enabled sample is recorded as ts=0 with no check against pre-reset values.

Test Plan:
- Reset, then clk_en=1 with inputs held at rc=0, pc=0, sc=0 for 5 cycles -> exactly one record, trace_data={8'd0, 3'd0, 2'd0, 2'd0}, trace_valid=1, trace_count=1, seq_error=0.
- Drive sc 0->1->2->3->0 over 4 enabled cycles (rc, pc fixed), trace_ready=0 -> 5 records with ts 0..4, seq_error=0. Then set trace_ready=1 -> records drain in order and trace_valid=0 after 5 pops.
- Drive sc 1->3 at ts=6 with rc=2, pc=1 -> seq_error=1, err_snapshot={3'd2,2'd1,2'd1, 3'd2,2'd1,2'd3}. A later 0->2 jump leaves err_snapshot unchanged.
- DEPTH=8, trace_ready=0, 12 changing samples -> trace_count=8, overflow=1, drop_count=4, and the head is the first record. With full and trace_ready=1 while a change is sampled -> no new drop, count stays 8.
- Toggle clk_en low for 3 cycles while the inputs change, then high -> no records during the low phase. The next record's ts equals the last ts+1, and one record reflects the current inputs.
- Assert reset mid-drain with trace_count=5 -> all outputs 0 asynchronously. After release, the first enabled sample yields ts=0.

Source files
------------

// File: rtl/paper_trace_monitor.sv
// Passive trace monitor for the paperProcessor status outputs: timestamps each
// change of {registerCount, programCount, stateCount}, checks stateCount sequencing, buffers in a FIFO.
module paper_trace_monitor #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [2:0]               registerCount,
  input  logic [1:0]               programCount,
  input  logic [1:0]               stateCount,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TS_W+6:0]          trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  output logic                     seq_error,
  output logic [13:0]              err_snapshot
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 7;

  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [TS_W-1:0] ts;
  logic            primed;
  logic [6:0]      prev;
  logic [6:0]      cur;

  logic push, pop, full, do_write, do_drop, illegal;

  assign cur      = {registerCount, programCount, stateCount};
  assign push     = clk_en && (!primed || (cur != prev));
  assign pop      = (count != '0) && trace_ready;
  assign full     = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_write = push && (!full || pop);
  assign do_drop  = push && full && !pop;
  assign illegal  = clk_en && primed && (cur[1:0] != prev[1:0]) &&
                    (cur[1:0] != prev[1:0] + 2'd1);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= {ts, cur};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ts           <= '0;
      primed       <= 1'b0;
      prev         <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      seq_error    <= 1'b0;
      err_snapshot <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_write} - {{AW{1'b0}}, pop};
      if (clk_en) begin
        ts     <= ts + TS_W'(1);
        primed <= 1'b1;
        prev   <= cur;
      end
      if (do_drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (illegal) begin
        seq_error <= 1'b1;
        // Only the first offending transition is kept for post-mortem.
        if (!seq_error) err_snapshot <= {prev, cur};
      end
    end
  end

  assign trace_valid = (count != '0);
  assign trace_data  = trace_valid ? mem[rd_ptr] : '0;
  assign trace_count = count;

endmodule

// File: tb/tb_paper_trace_monitor.sv
// Directed bench for paper_trace_monitor: a vector table for the main stream
// plus hand-written sequences for overflow, clk_en gating and mid-stream reset.
module tb_paper_trace_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [2:0]  rc = '0;
  logic [1:0]  pc = '0;
  logic [1:0]  sc = '0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [14:0] trace_data;
  logic [3:0]  trace_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        seq_error;
  logic [13:0] err_snapshot;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  paper_trace_monitor #(.DEPTH(8), .TS_W(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .registerCount(rc), .programCount(pc), .stateCount(sc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_count(trace_count), .overflow(overflow), .drop_count(drop_count),
    .seq_error(seq_error), .err_snapshot(err_snapshot)
  );

  typedef struct packed {
    logic        en;
    logic [2:0]  rc;
    logic [1:0]  pc;
    logic [1:0]  sc;
    logic        rdy;
    logic        valid;
    logic [14:0] data;
    logic [3:0]  count;
    logic        seq;
    logic [13:0] snap;
  } vec_t;

  vec_t vecs[14];

  localparam logic [13:0] SNAP1 = {3'd2, 2'd1, 2'd1, 3'd2, 2'd1, 2'd3};

  function automatic logic [14:0] mk(input int t, input int r, input int p, input int s);
    return {8'(t), 3'(r), 2'(p), 2'(s)};
  endfunction

  function automatic vec_t mkvec(input int en, input int r, input int p, input int s, input int rdy,
                                 input int valid, input logic [14:0] data, input int cnt,
                                 input int seq, input logic [13:0] snap);
    vec_t v;
    v.en = 1'(en); v.rc = 3'(r); v.pc = 2'(p); v.sc = 2'(s); v.rdy = 1'(rdy);
    v.valid = 1'(valid); v.data = data; v.count = 4'(cnt); v.seq = 1'(seq); v.snap = snap;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int en, input int r, input int p, input int s, input int rdy);
    clk_en = 1'(en); rc = 3'(r); pc = 2'(p); sc = 2'(s); trace_ready = 1'(rdy);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(trace_valid), 0);
    chk({tag, ".data"}, 32'(trace_data), 0);
    chk({tag, ".count"}, 32'(trace_count), 0);
    chk({tag, ".overflow"}, 32'(overflow), 0);
    chk({tag, ".drop"}, 32'(drop_count), 0);
    chk({tag, ".seq"}, 32'(seq_error), 0);
    chk({tag, ".snap"}, 32'(err_snapshot), 0);
  endtask

  initial begin
    // Fill with rc=1,pc=2 and sc 0->1->2->3->0, drain, then 1->3 and 0->2 errors.
    vecs[0]  = mkvec(1, 1, 2, 0, 0, 1, mk(0, 1, 2, 0), 1, 0, 0);
    vecs[1]  = mkvec(1, 1, 2, 1, 0, 1, mk(0, 1, 2, 0), 2, 0, 0);
    vecs[2]  = mkvec(1, 1, 2, 2, 0, 1, mk(0, 1, 2, 0), 3, 0, 0);
    vecs[3]  = mkvec(1, 1, 2, 3, 0, 1, mk(0, 1, 2, 0), 4, 0, 0);
    vecs[4]  = mkvec(1, 1, 2, 0, 0, 1, mk(0, 1, 2, 0), 5, 0, 0);
    vecs[5]  = mkvec(0, 1, 2, 0, 1, 1, mk(1, 1, 2, 1), 4, 0, 0);
    vecs[6]  = mkvec(0, 1, 2, 0, 1, 1, mk(2, 1, 2, 2), 3, 0, 0);
    vecs[7]  = mkvec(0, 1, 2, 0, 1, 1, mk(3, 1, 2, 3), 2, 0, 0);
    vecs[8]  = mkvec(0, 1, 2, 0, 1, 1, mk(4, 1, 2, 0), 1, 0, 0);
    vecs[9]  = mkvec(0, 1, 2, 0, 1, 0, 15'd0,          0, 0, 0);
    vecs[10] = mkvec(1, 2, 1, 1, 0, 1, mk(5, 2, 1, 1), 1, 0, 0);
    vecs[11] = mkvec(1, 2, 1, 3, 0, 1, mk(5, 2, 1, 1), 2, 1, SNAP1);
    vecs[12] = mkvec(1, 2, 1, 0, 0, 1, mk(5, 2, 1, 1), 3, 1, SNAP1);
    vecs[13] = mkvec(1, 2, 1, 2, 0, 1, mk(5, 2, 1, 1), 4, 1, SNAP1);

    // Reset state and steady inputs give a single record.
    apply_reset();
    chk_all_zero("reset");
    drive(1, 0, 0, 0, 0);
    repeat (5) tick();
    chk("hold.valid", 32'(trace_valid), 1);
    chk("hold.data", 32'(trace_data), 32'(mk(0, 0, 0, 0)));
    chk("hold.count", 32'(trace_count), 1);
    chk("hold.seq", 32'(seq_error), 0);

    // Table-driven main stream.
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].en, vecs[i].rc, vecs[i].pc, vecs[i].sc, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d.valid", i), 32'(trace_valid), 32'(vecs[i].valid));
      chk($sformatf("vec%0d.data", i), 32'(trace_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d.count", i), 32'(trace_count), 32'(vecs[i].count));
      chk($sformatf("vec%0d.seq", i), 32'(seq_error), 32'(vecs[i].seq));
      chk($sformatf("vec%0d.snap", i), 32'(err_snapshot), 32'(vecs[i].snap));
    end

    // Overflow: 12 changing samples into an 8-deep FIFO.
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, i % 8, 1, i % 4, 0);
      tick();
      chk($sformatf("ovf%0d.count", i), 32'(trace_count), 32'((i + 1 > 8) ? 8 : i + 1));
      chk($sformatf("ovf%0d.drop", i), 32'(drop_count), 32'((i > 7) ? i - 7 : 0));
      chk($sformatf("ovf%0d.overflow", i), 32'(overflow), 32'(i > 7));
    end
    chk("ovf.head", 32'(trace_data), 32'(mk(0, 0, 1, 0)));
    drive(1, 12 % 8, 1, 12 % 4, 1);
    tick();
    chk("fullpp.count", 32'(trace_count), 8);
    chk("fullpp.drop", 32'(drop_count), 4);
    chk("fullpp.head", 32'(trace_data), 32'(mk(1, 1, 1, 1)));
    for (int i = 13; i < 313; i++) begin
      drive(1, i % 8, 1, i % 4, 0);
      tick();
    end
    chk("sat.drop", 32'(drop_count), 255);
    chk("sat.overflow", 32'(overflow), 1);
    chk("sat.count", 32'(trace_count), 8);

    // clk_en low freezes sampling and the timestamp.
    apply_reset();
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 1, 0); tick();
    drive(0, 2, 0, 2, 0); tick();
    drive(0, 3, 0, 3, 0); tick();
    drive(0, 4, 0, 0, 0); tick();
    chk("gate.count_low", 32'(trace_count), 2);
    drive(1, 5, 0, 2, 0); tick();
    chk("gate.count_high", 32'(trace_count), 3);
    chk("gate.seq", 32'(seq_error), 0);
    drive(0, 5, 0, 2, 1); tick(); tick();
    chk("gate.rec", 32'(trace_data), 32'(mk(2, 5, 0, 2)));
    chk("gate.remaining", 32'(trace_count), 1);

    // Asynchronous reset mid-stream with five records and a latched error.
    apply_reset();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 2, 0); tick();
    drive(1, 0, 0, 3, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0); tick();
    chk("pre.count", 32'(trace_count), 5);
    chk("pre.seq", 32'(seq_error), 1);
    drive(0, 0, 0, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async");
    tick();
    reset = 1'b0;
    drive(1, 7, 3, 2, 0);
    tick();
    chk("post.valid", 32'(trace_valid), 1);
    chk("post.data", 32'(trace_data), 32'(mk(0, 7, 3, 2)));
    chk("post.count", 32'(trace_count), 1);
    chk("post.seq", 32'(seq_error), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
